gear16to24: RTL and testbench

- Receive-side counterpart of the 24-to-16 gearbox.
- Repacks a framed 16-bit word stream (dav/fst/lst qualified) back into 24-bit words: every 3 input words become 2 output words.
- Sits on the 192 MHz link side, after the link receiver and before the 24-bit event buffer.
- Restores frame markers, strips the pad byte of odd-length frames, and flags framing and pad errors.

---
 rtl/gear16to24_pkg.sv | 14 +
 rtl/gear16to24_if.sv | 26 ++
 rtl/gear16to24.sv | 132 +++++++++++++
 tb/tb_gear16to24.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gear16to24_pkg.sv
// Shared constants for the 24<->16 gearbox pair.
// Phase encoding and the pad byte must match the transmitter.
package gear_pkg;
    localparam int W16 = 16;
    localparam int W24 = 24;

    localparam logic [7:0] PAD_VAL_DEF = 8'h00;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } ph_e;
endpackage

// File: rtl/gear16to24_if.sv
// Framed 16-bit input stream and repacked 24-bit output stream.
// The master drives the link words; the slave is the gearbox.
interface gear16to24_if;
    import gear_pkg::*;

    logic [W16-1:0] datin;
    logic           davin;
    logic           fstin;
    logic           lstin;
    logic [W24-1:0] datout;
    logic           davout;
    logic           fstout;
    logic           lstout;
    logic           err_frm;
    logic           err_pad;

    modport master (
        output datin, davin, fstin, lstin,
        input  datout, davout, fstout, lstout, err_frm, err_pad
    );

    modport slave (
        input  datin, davin, fstin, lstin,
        output datout, davout, fstout, lstout, err_frm, err_pad
    );
endinterface

// File: rtl/gear16to24.sv
// Receive gearbox: packs three framed 16-bit words into two 24-bit words.
// Restores frame markers, drops the odd-frame pad byte, flags errors.
module gear16to24
    import gear_pkg::*;
#(
    parameter logic [7:0] PAD_VAL   = PAD_VAL_DEF,
    parameter bit         CHECK_PAD = 1'b1
) (
    input  logic         clk192,
    input  logic         init,
    gear16to24_if.slave  bus
);

    ph_e            ph_q, ph_d, ph_eff;
    logic [W16-1:0] hold_q, hold_d;
    logic           open_q, open_d;
    logic           fpend_q, fpend_d;

    logic [W24-1:0] datout_q, datout_d;
    logic           davout_q, davout_d;
    logic           fstout_q, fstout_d;
    logic           lstout_q, lstout_d;
    logic           err_frm_q, err_frm_d;
    logic           err_pad_q, err_pad_d;

    logic           acc;

    assign acc    = bus.davin & (bus.fstin | open_q);
    assign ph_eff = bus.fstin ? PH0 : ph_q;

    always_ff @(posedge clk192 or posedge init) begin
        if (init) begin
            ph_q      <= PH0;
            hold_q    <= '0;
            open_q    <= 1'b0;
            fpend_q   <= 1'b0;
            datout_q  <= '0;
            davout_q  <= 1'b0;
            fstout_q  <= 1'b0;
            lstout_q  <= 1'b0;
            err_frm_q <= 1'b0;
            err_pad_q <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            hold_q    <= hold_d;
            open_q    <= open_d;
            fpend_q   <= fpend_d;
            datout_q  <= datout_d;
            davout_q  <= davout_d;
            fstout_q  <= fstout_d;
            lstout_q  <= lstout_d;
            err_frm_q <= err_frm_d;
            err_pad_q <= err_pad_d;
        end
    end

    always_comb begin
        ph_d      = ph_q;
        hold_d    = hold_q;
        open_d    = open_q;
        fpend_d   = fpend_q;
        datout_d  = '0;
        davout_d  = 1'b0;
        fstout_d  = 1'b0;
        lstout_d  = 1'b0;
        err_frm_d = err_frm_q;
        err_pad_d = err_pad_q;

        // Word outside any frame is dropped.
        if (bus.davin && !bus.fstin && !open_q)
            err_frm_d = 1'b1;

        if (acc) begin
            if (bus.fstin) begin
                open_d  = 1'b1;
                fpend_d = 1'b1;
                if (open_q)
                    err_frm_d = 1'b1;
            end

            unique case (1'b1)
                (ph_eff == PH0): begin
                    if (bus.lstin) begin
                        davout_d  = 1'b1;
                        datout_d  = {bus.datin, 8'h00};
                        err_frm_d = 1'b1;
                    end else begin
                        hold_d = bus.datin;
                        ph_d   = PH1;
                    end
                end
                (ph_eff == PH1): begin
                    davout_d = 1'b1;
                    datout_d = {hold_q, bus.datin[15:8]};
                    if (bus.lstin) begin
                        if (CHECK_PAD && bus.datin[7:0] != PAD_VAL)
                            err_pad_d = 1'b1;
                    end else begin
                        hold_d[7:0] = bus.datin[7:0];
                        ph_d        = PH2;
                    end
                end
                (ph_eff == PH2): begin
                    davout_d = 1'b1;
                    datout_d = {hold_q[7:0], bus.datin};
                    ph_d     = PH0;
                end
                default: ph_d = PH0;
            endcase

            if (bus.lstin) begin
                lstout_d = davout_d;
                ph_d     = PH0;
                open_d   = 1'b0;
            end

            // A fresh fst wins over any stale pending marker.
            if (davout_d) begin
                fstout_d = bus.fstin | fpend_q;
                fpend_d  = 1'b0;
            end
        end
    end

    assign bus.datout  = datout_q;
    assign bus.davout  = davout_q;
    assign bus.fstout  = fstout_q;
    assign bus.lstout  = lstout_q;
    assign bus.err_frm = err_frm_q;
    assign bus.err_pad = err_pad_q;

endmodule

// File: tb/tb_gear16to24.sv
// Randomized scoreboard bench for gear16to24.
// A byte-queue frame model predicts outputs; a monitor checks them.
module tb_gear16to24;

    logic clk192 = 1'b0;
    logic init   = 1'b1;

    gear16to24_if bus();

    gear16to24 dut (
        .clk192 (clk192),
        .init   (init),
        .bus    (bus)
    );

    always #5 clk192 = ~clk192;

    typedef struct {
        logic [23:0] d;
        bit          f;
        bit          l;
        int          cyc;
    } exp_t;

    exp_t     expq[$];
    bit [7:0] bq[$];
    bit       mopen, mfirst, merr_frm, merr_pad;
    int       cnt;
    int       checks = 0;
    int       errors = 0;

    always @(posedge clk192) cnt <= cnt + 1;

    // Frame model: bytes accumulate, every 3 bytes form one output word.
    task automatic model(input logic [15:0] d, input bit f, input bit l);
        exp_t e;
        bit   emitted;
        if (!f && !mopen) begin
            merr_frm = 1'b1;
            return;
        end
        if (f) begin
            if (mopen) merr_frm = 1'b1;
            bq.delete();
            mopen  = 1'b1;
            mfirst = 1'b1;
        end
        bq.push_back(d[15:8]);
        bq.push_back(d[7:0]);
        emitted = 1'b0;
        if (bq.size() >= 3) begin
            e.d   = {bq[0], bq[1], bq[2]};
            e.f   = mfirst;
            e.l   = l;
            e.cyc = cnt + 1;
            expq.push_back(e);
            repeat (3) void'(bq.pop_front());
            mfirst  = 1'b0;
            emitted = 1'b1;
        end
        if (l) begin
            if (!emitted) begin
                e.d   = {bq[0], bq[1], 8'h00};
                e.f   = mfirst;
                e.l   = 1'b1;
                e.cyc = cnt + 1;
                expq.push_back(e);
                merr_frm = 1'b1;
            end else if (bq.size() == 1 && bq[0] != 8'h00) begin
                merr_pad = 1'b1;
            end
            bq.delete();
            mopen  = 1'b0;
            mfirst = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] d, input bit f, input bit l);
        @(negedge clk192);
        bus.datin = d;
        bus.davin = 1'b1;
        bus.fstin = f;
        bus.lstin = l;
        model(d, f, l);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk192);
            bus.datin = 16'($urandom);
            bus.davin = 1'b0;
            bus.fstin = 1'($urandom);
            bus.lstin = 1'($urandom);
        end
    endtask

    task automatic chk_err(input string name);
        idle(2);
        checks++;
        if (bus.err_frm !== merr_frm || bus.err_pad !== merr_pad) begin
            errors++;
            $display("FAIL %s: err_frm=%b err_pad=%b, required %b %b",
                     name, bus.err_frm, bus.err_pad, merr_frm, merr_pad);
        end
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (bus.datout !== 24'h0 || bus.davout !== 1'b0 ||
            bus.fstout !== 1'b0 || bus.lstout !== 1'b0 ||
            bus.err_frm !== 1'b0 || bus.err_pad !== 1'b0) begin
            errors++;
            $display("FAIL %s: dat=%h dav=%b fst=%b lst=%b ef=%b ep=%b, required all 0",
                     name, bus.datout, bus.davout, bus.fstout, bus.lstout,
                     bus.err_frm, bus.err_pad);
        end
    endtask

    task automatic model_clear();
        bq.delete();
        expq.delete();
        mopen    = 1'b0;
        mfirst   = 1'b0;
        merr_frm = 1'b0;
        merr_pad = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk192);
        init      = 1'b1;
        bus.davin = 1'b0;
        model_clear();
        @(negedge clk192);
        init = 1'b0;
        chk_zero("reset");
    endtask

    task automatic gap();
        idle($urandom_range(0, 3));
    endtask

    // Monitor: compare every output strobe against the scoreboard head.
    always @(posedge clk192) begin
        exp_t e;
        #1;
        if (!init) begin
            if (bus.davout) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: dat=%h fst=%b lst=%b, required no output",
                             bus.datout, bus.fstout, bus.lstout);
                end else begin
                    e = expq.pop_front();
                    if (bus.datout !== e.d || bus.fstout !== e.f ||
                        bus.lstout !== e.l || cnt != e.cyc) begin
                        errors++;
                        $display("FAIL out_word: dat=%h fst=%b lst=%b cyc=%0d, required %h %b %b cyc=%0d",
                                 bus.datout, bus.fstout, bus.lstout, cnt,
                                 e.d, e.f, e.l, e.cyc);
                    end
                end
            end else if (bus.datout !== 24'h0 || bus.fstout || bus.lstout) begin
                checks++;
                errors++;
                $display("FAIL idle_out: dat=%h fst=%b lst=%b, required 0 0 0",
                         bus.datout, bus.fstout, bus.lstout);
            end
        end
    end

    initial begin
        int len;
        int r;
        bus.datin = '0;
        bus.davin = 1'b0;
        bus.fstin = 1'b0;
        bus.lstin = 1'b0;
        cnt       = 0;
        model_clear();
        #1;
        chk_zero("async_reset_start");

        do_reset();
        send(16'h1122, 1, 0);
        send(16'h3344, 0, 0);
        send(16'h5566, 0, 1);
        chk_err("three_word_frame");

        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(16'($urandom), i == 0, i == 5);
            gap();
        end
        chk_err("six_word_gaps");

        do_reset();
        send(16'hAABB, 1, 0);
        send(16'hCC00, 0, 1);
        chk_err("odd_frame_pad_ok");
        send(16'hAABB, 1, 0);
        send(16'hCC5A, 0, 1);
        chk_err("odd_frame_pad_bad");

        do_reset();
        send(16'h0102, 1, 0);
        send(16'h0304, 1, 0);
        send(16'h0506, 0, 0);
        send(16'h0708, 0, 1);
        chk_err("restart_mid_word");

        do_reset();
        send(16'h1234, 0, 0);
        chk_err("orphan_word");
        send(16'h1122, 1, 0);
        send(16'h3344, 0, 0);
        @(posedge clk192);
        #3;
        init = 1'b1;
        #1;
        chk_zero("async_reset_mid_frame");
        @(negedge clk192);
        bus.davin = 1'b0;
        model_clear();
        init = 1'b0;
        send(16'h5566, 0, 1);
        chk_err("after_reset_orphan");

        do_reset();
        send(16'hBEEF, 1, 1);
        chk_err("fst_lst_same_word");

        do_reset();
        for (int n = 0; n < 150; n++) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 9);
            if (r == 0) begin
                send(16'($urandom), 0, 0);
                gap();
            end
            for (int i = 0; i < len; i++) begin
                logic [15:0] d;
                d = 16'($urandom);
                if (i == len - 1 && $urandom_range(0, 1) == 0)
                    d[7:0] = 8'h00;
                send(d, i == 0, (i == len - 1) && (r != 1));
                gap();
            end
            if (n % 50 == 49)
                chk_err("random_errors");
        end
        idle(3);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs: %0d pending, required 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
